// File: rtl/bloom_lut_pkg.sv
// bloom_lut_pkg: shared FSM states, latencies and block indexing for the Bloom LUT bank.
package bloom_lut_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RD_WAIT} state_t;
  localparam int LOOKUP_LAT = 2;
  localparam int RD_LAT = 2;
  localparam int STATS_REGION_BIT = 31;
  function automatic int blk_index(input int ch, input int h, input int hashes);
    return ch * hashes + h;
  endfunction
endpackage

// File: rtl/bloom_lut_ctrl.sv
// bloom_lut_ctrl: port-B side FSM: Avalon-MM decode, single outstanding read, bulk clear sweep.
module bloom_lut_ctrl
  import bloom_lut_pkg::*;
#(
  parameter int NBLK = 78,
  parameter int HASH_W = 12,
  parameter int CH_CNT = 13,
  parameter int AMM_ADDR_W = 32,
  parameter int AMM_DATA_W = 32,
  localparam int BLK_W = $clog2(NBLK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg,
  input  logic                  clear,
  output logic                  busy,
  input  logic [AMM_ADDR_W-1:0] address,
  input  logic                  write,
  input  logic [AMM_DATA_W-1:0] writedata,
  input  logic                  read,
  output logic [AMM_DATA_W-1:0] readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  output logic [HASH_W-1:0]     b_addr,
  output logic [NBLK-1:0]       b_we,
  output logic                  b_wdata,
  input  logic [NBLK-1:0]       b_q,
  input  logic [CH_CNT*32-1:0]  stats
);
  state_t state;
  logic [HASH_W-1:0] cnt;
  logic [BLK_W-1:0] blk, rd_sel;
  logic [AMM_DATA_W-1:0] rd_word;
  logic pend, rd_zero, rd_stats, stat_reg, blk_ok, wr_go, rd_go, unused;
  assign blk = address[HASH_W +: BLK_W];
  assign stat_reg = address[STATS_REGION_BIT];
  assign blk_ok = 32'(blk) < NBLK;
  assign wr_go = state == IDLE && write && cfg && !stat_reg && blk_ok;
  assign rd_go = state == IDLE && read && !write;
  assign busy = state == CLEAR;
  assign waitrequest = state != IDLE;
  assign b_addr = busy ? cnt : address[HASH_W-1:0];
  assign b_wdata = !busy && writedata[0];
  assign b_we = {NBLK{busy}} | ({{(NBLK-1){1'b0}}, wr_go} << blk);
  assign rd_word = rd_stats ? AMM_DATA_W'(stats[32*rd_sel +: 32]) : AMM_DATA_W'(b_q[rd_sel]);
  assign unused = ^{writedata[AMM_DATA_W-1:1], address[STATS_REGION_BIT-1:HASH_W+BLK_W]};
  // a clear that arrives mid-read is held in pend and taken once the read retires
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pend <= 1'b0;
      rd_zero <= 1'b0;
      rd_stats <= 1'b0;
      rd_sel <= '0;
      readdata <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdata <= '0;
      readdatavalid <= 1'b0;
      case (state)
        IDLE:
          if (rd_go) begin
            state <= RD_WAIT;
            cnt <= '0;
            pend <= pend | clear;
            rd_stats <= stat_reg;
            rd_zero <= !cfg || (stat_reg ? 32'(address[HASH_W-1:0]) >= CH_CNT : !blk_ok);
            rd_sel <= stat_reg ? address[BLK_W-1:0] : blk;
          end else if (clear || pend) begin
            state <= CLEAR;
            cnt <= '0;
            pend <= 1'b0;
          end
        RD_WAIT: begin
          readdatavalid <= cnt == HASH_W'(RD_LAT-2);
          readdata <= (cnt == HASH_W'(RD_LAT-2) && !rd_zero) ? rd_word : '0;
          if (cnt == HASH_W'(RD_LAT-1)) begin
            state <= (pend || clear) ? CLEAR : IDLE;
            cnt <= '0;
            pend <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            pend <= pend | clear;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/true_dp_ram.sv
// true_dp_ram: dual-port RAM, both ports read-first with a one-cycle registered read.
module true_dp_ram #(
  parameter int DATA_W = 1,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_q,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_q
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    a_q <= mem[a_addr];
    b_q <= mem[b_addr];
  end
endmodule

// File: rtl/bloom_lut_bank.sv
// bloom_lut_bank: Bloom-filter LUT bank; port A serves lookups, port B serves AMM access and clear.
// Define BLOOM_LUT_STATS_EN for per-channel saturating match counters in the stats region.
module bloom_lut_bank
  import bloom_lut_pkg::*;
#(
  parameter int CH_CNT = 13,
  parameter int HASHES_CNT = 6,
  parameter int HASH_W = 12,
  parameter int AMM_ADDR_W = 32,
  parameter int AMM_DATA_W = 32
) (
  input  logic                                clk_i,
  input  logic                                srst_i,
  input  logic                                config_i,
  input  logic                                clear_i,
  output logic                                busy_o,
  input  logic [AMM_ADDR_W-1:0]               amm_slave_lut_address_i,
  input  logic                                amm_slave_lut_write_i,
  input  logic [AMM_DATA_W-1:0]               amm_slave_lut_writedata_i,
  input  logic                                amm_slave_lut_read_i,
  output logic [AMM_DATA_W-1:0]               amm_slave_lut_readdata_o,
  output logic                                amm_slave_lut_readdatavalid_o,
  output logic                                amm_slave_lut_waitrequest_o,
  input  logic                                lookup_valid_i,
  input  logic [CH_CNT*HASHES_CNT*HASH_W-1:0] lookup_addr_i,
  output logic [CH_CNT*HASHES_CNT-1:0]        hit_bits_o,
  output logic [CH_CNT-1:0]                   match_o,
  output logic                                match_valid_o
);
  localparam int NBLK = CH_CNT * HASHES_CNT;
  logic [HASH_W-1:0] b_addr;
  logic [NBLK-1:0] b_we, b_q, a_q;
  logic [LOOKUP_LAT-1:0] vld;
  logic [CH_CNT*32-1:0] stats;
  logic b_wdata, gate;
  bloom_lut_ctrl #(
    .NBLK(NBLK), .HASH_W(HASH_W), .CH_CNT(CH_CNT), .AMM_ADDR_W(AMM_ADDR_W), .AMM_DATA_W(AMM_DATA_W)
  ) u_ctrl (
    .clk(clk_i), .rst(srst_i), .cfg(config_i), .clear(clear_i), .busy(busy_o),
    .address(amm_slave_lut_address_i), .write(amm_slave_lut_write_i),
    .writedata(amm_slave_lut_writedata_i), .read(amm_slave_lut_read_i),
    .readdata(amm_slave_lut_readdata_o), .readdatavalid(amm_slave_lut_readdatavalid_o),
    .waitrequest(amm_slave_lut_waitrequest_o),
    .b_addr(b_addr), .b_we(b_we), .b_wdata(b_wdata), .b_q(b_q), .stats(stats)
  );
  for (genvar c = 0; c < CH_CNT; c++) begin : g_ch
    for (genvar h = 0; h < HASHES_CNT; h++) begin : g_h
      localparam int B = blk_index(c, h, HASHES_CNT);
      true_dp_ram #(.DATA_W(1), .ADDR_W(HASH_W)) u_ram (
        .clk(clk_i),
        .a_addr(lookup_addr_i[B*HASH_W +: HASH_W]), .a_we(1'b0), .a_wdata(1'b0), .a_q(a_q[B]),
        .b_addr(b_addr), .b_we(b_we[B]), .b_wdata(b_wdata), .b_q(b_q[B])
      );
    end
  end
  // gate travels with the lookup so results issued during config or clear read as zero
  always_ff @(posedge clk_i)
    if (srst_i) begin
      vld <= '0;
      gate <= 1'b0;
      hit_bits_o <= '0;
      match_o <= '0;
    end else begin
      vld <= {vld[LOOKUP_LAT-2:0], lookup_valid_i};
      gate <= config_i | busy_o;
      hit_bits_o <= gate ? '0 : a_q;
      for (int c = 0; c < CH_CNT; c++) match_o[c] <= !gate && &a_q[c*HASHES_CNT +: HASHES_CNT];
    end
  assign match_valid_o = vld[LOOKUP_LAT-1];
`ifdef BLOOM_LUT_STATS_EN
  logic [31:0] hits [CH_CNT];
  always_ff @(posedge clk_i)
    for (int c = 0; c < CH_CNT; c++)
      if (srst_i || busy_o) hits[c] <= '0;
      else if (match_valid_o && match_o[c] && !(&hits[c])) hits[c] <= hits[c] + 1'b1;
  always_comb begin
    stats = '0;
    for (int c = 0; c < CH_CNT; c++) stats[c*32 +: 32] = hits[c];
  end
`else
  assign stats = '0;
`endif
endmodule
